// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath: loader FSM encoding and the
// row-major packing rule used by the loader, the result unpacker and benches.
package matrix_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } load_state_e;

    // MSB bit position of row-major element k in a packed vector of n elements.
    function automatic int unsigned msb_offset(input int unsigned n,
                                               input int unsigned k,
                                               input int unsigned w);
        return n * w - 1 - k * w;
    endfunction

endpackage

// File: rtl/word_shift_reg.sv
// Word-wide shift register with parallel output; each shift moves the contents
// up by one word and inserts din at the LSBs, so the first word ends up on top.
module word_shift_reg #(
    parameter int word_size = 32,
    parameter int depth     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       shift_en,
    input  logic [word_size-1:0]       din,
    output logic [depth*word_size-1:0] q
);

    logic [depth*word_size-1:0] q_q;
    logic [depth*word_size-1:0] q_d;

    generate
        if (depth == 1) begin : g_single
            assign q_d = din;
        end else begin : g_multi
            assign q_d = {q_q[(depth-1)*word_size-1:0], din};
        end
    endgenerate

    // NOTE: the whole register is reset and cleared, not just a valid flag, so
    // no data from an aborted load can ever reappear on q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (shift_en) begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/matrix_operand_loader.sv
// Streams A then B in row-major order into the packed operand vectors used by
// matrix_mul, then holds them under an out_valid/out_ready handshake.
module matrix_operand_loader
    import matrix_pkg::*;
#(
    parameter int word_size     = 32,
    parameter int Amatrixrownum = 2,
    parameter int Amatrixcolnum = 2,
    parameter int Bmatrixrownum = 2,
    parameter int Bmatrixcolnum = 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           clr,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [word_size-1:0]                           in_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [Amatrixrownum*Amatrixcolnum*word_size-1:0] A,
    output logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0] B
);

    localparam int NA      = Amatrixrownum * Amatrixcolnum;
    localparam int NB      = Bmatrixrownum * Bmatrixcolnum;
    localparam int CNT_MAX = (NA > NB) ? NA : NB;
    localparam int CW      = $clog2(CNT_MAX + 1);

    generate
        if (Amatrixcolnum != Bmatrixrownum || Amatrixcolnum < 2) begin : g_bad_dims
            $fatal(1, "matrix_operand_loader: inner dimensions must match and be >= 2");
        end
    endgenerate

    load_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic          accept;
    logic          shift_a;
    logic          shift_b;

    // Ready is a pure function of state: no combinational path from the handshakes.
    assign in_ready  = (state_q != HOLD);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        shift_a     = 1'b0;
        shift_b     = 1'b0;
        if (clr) begin
            state_d     = LOAD_A;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (accept) begin
                        shift_a = 1'b1;
                        if (cnt_q == CW'(NA - 1)) begin
                            cnt_d   = '0;
                            state_d = LOAD_B;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        shift_b = 1'b1;
                        if (cnt_q == CW'(NB - 1)) begin
                            cnt_d       = '0;
                            state_d     = HOLD;
                            out_valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = LOAD_A;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    word_shift_reg #(
        .word_size (word_size),
        .depth     (NA)
    ) u_a_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .shift_en (shift_a),
        .din      (in_data),
        .q        (A)
    );

    word_shift_reg #(
        .word_size (word_size),
        .depth     (NB)
    ) u_b_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .shift_en (shift_b),
        .din      (in_data),
        .q        (B)
    );

endmodule
